tlul_host_arb: RTL and testbench

//   M:1 TL-UL arbiter: shares one device port (typically the host side of a 1:N socket) among M hosts.

---
 rtl/tlul_host_arb_if.sv | 46 ++++
 rtl/tlul_host_arb.sv | 129 ++++++++++++
 tb/tb_tlul_host_arb.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_host_arb_if.sv
// TL-UL request/response types and the bundle connecting M hosts and one device
// to the host arbiter.
package tlul_host_arb_pkg;
  localparam int TL_AIW = 8;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_AIW-1:0] a_source;
    logic [31:0]       a_address;
    logic [3:0]        a_mask;
    logic [31:0]       a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [1:0]        d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [31:0]       d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

interface tlul_host_arb_if #(
  parameter int M = 3
);
  import tlul_host_arb_pkg::*;
  localparam int HW = $clog2(M);

  tl_h2d_t         tl_h_req [M];
  tl_d2h_t         tl_h_rsp [M];
  tl_h2d_t         tl_d_req;
  tl_d2h_t         tl_d_rsp;
  logic [HW-1:0]   gnt_idx;
  logic            busy;

  modport slave  (input  tl_h_req, tl_d_rsp, output tl_h_rsp, tl_d_req, gnt_idx, busy);
  modport master (output tl_h_req, tl_d_rsp, input  tl_h_rsp, tl_d_req, gnt_idx, busy);
endinterface

// File: rtl/tlul_host_arb.sv
// M:1 TL-UL arbiter: round-robin grant held across device stalls, per-host
// outstanding limit, host index carried in the low a_source bits for response routing.
module tlul_host_arb
  import tlul_host_arb_pkg::*;
#(
  parameter int M           = 3,
  parameter int MaxOutstand = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  tlul_host_arb_if.slave  bus
);
  localparam int HW = $clog2(M);
  localparam int CW = 4;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e          state_q;
  logic [HW-1:0]   grant_q;
  logic [HW-1:0]   last_q;
  logic [CW-1:0]   cnt_q [M];

  logic [M-1:0]    eligible;
  logic [M-1:0]    rsp_accept;
  logic [HW-1:0]   rr_pick;
  logic [HW-1:0]   grant;
  logic [HW-1:0]   rsp_tag;
  logic            found;
  logic            req_valid;
  logic            req_accept;
  logic            tag_legal;

  // Round-robin search starts just after the host accepted last.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    rr_pick = '0;
    for (int k = 1; k <= M; k++) begin
      idx = int'(last_q) + k;
      if (idx >= M) idx = idx - M;
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        rr_pick = HW'(idx);
      end
    end
  end

  assign grant      = (state_q == LOCK) ? grant_q : rr_pick;
  assign req_valid  = (state_q == LOCK) ? bus.tl_h_req[grant_q].a_valid : found;
  assign req_accept = req_valid && bus.tl_d_rsp.a_ready;
  assign rsp_tag    = bus.tl_d_rsp.d_source[HW-1:0];
  assign tag_legal  = int'(rsp_tag) < M;
  assign bus.gnt_idx = grant;

  always_comb begin
    bus.tl_d_req          = bus.tl_h_req[grant];
    bus.tl_d_req.a_valid  = req_valid;
    bus.tl_d_req.a_source = {bus.tl_h_req[grant].a_source[TL_AIW-HW-1:0], grant};
    // Illegal tags are sunk so the device never stalls on them.
    bus.tl_d_req.d_ready  = tag_legal ? bus.tl_h_req[rsp_tag].d_ready : 1'b1;
  end

  always_comb begin
    rsp_accept = '0;
    for (int i = 0; i < M; i++) begin
      bus.tl_h_rsp[i]          = bus.tl_d_rsp;
      bus.tl_h_rsp[i].d_source = {{HW{1'b0}}, bus.tl_d_rsp.d_source[TL_AIW-1:HW]};
      bus.tl_h_rsp[i].d_valid  = bus.tl_d_rsp.d_valid && (rsp_tag == HW'(i));
      bus.tl_h_rsp[i].a_ready  = req_valid && (grant == HW'(i)) &&
                                 bus.tl_d_rsp.a_ready && bus.tl_h_req[i].a_valid;
      rsp_accept[i]            = bus.tl_d_rsp.d_valid && (rsp_tag == HW'(i)) &&
                                 bus.tl_h_req[i].d_ready;
    end
  end

  always_comb begin
    bus.busy = 1'b0;
    for (int i = 0; i < M; i++) bus.busy = bus.busy | (|cnt_q[i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= HW'(M - 1);
    end else begin
      case (state_q)
        IDLE: if (found && !bus.tl_d_rsp.a_ready) begin
          state_q <= LOCK;
          grant_q <= rr_pick;
        end
        LOCK: if (req_accept) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (req_accept) last_q <= grant;
    end
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_host
    logic inc;
    logic dec;

    assign eligible[gi] = bus.tl_h_req[gi].a_valid && (cnt_q[gi] < CW'(MaxOutstand));
    assign inc          = req_accept && (grant == HW'(gi));
    assign dec          = rsp_accept[gi];

    // Decrement saturates so stale responses after a reset cannot wrap the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q[gi] <= '0;
      end else if (inc && !dec) begin
        cnt_q[gi] <= cnt_q[gi] + 1'b1;
      end else if (dec && !inc && (cnt_q[gi] != '0)) begin
        cnt_q[gi] <= cnt_q[gi] - 1'b1;
      end
    end

    a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q[gi] <= CW'(MaxOutstand));
    a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec && !inc && (cnt_q[gi] == '0)));
    a_src_msb_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.tl_h_req[gi].a_valid |-> (bus.tl_h_req[gi].a_source[TL_AIW-1:TL_AIW-HW] == '0));
  end

  a_tag_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.tl_d_rsp.d_valid |-> tag_legal);
endmodule

// File: tb/tb_tlul_host_arb.sv
// Bench for tlul_host_arb: scoreboard of expected device-side requests and
// host-side responses, plus direct checks of grant, hold, limit and reset behaviour.
module tb_tlul_host_arb;
  import tlul_host_arb_pkg::*;

  localparam int M  = 3;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  tlul_host_arb_if #(.M(M)) bus ();

  tlul_host_arb #(.M(M), .MaxOutstand(MO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          host;
    logic [7:0]  src;
    logic [31:0] addr;
  } req_t;

  typedef struct {
    int          host;
    logic [7:0]  src;
  } rsp_t;

  req_t exp_req [$];
  rsp_t exp_rsp [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] src_of(input int h);
    return 8'(8'h10 + h);
  endfunction

  function automatic logic [31:0] addr_of(input int h);
    return 32'hA000_0000 + 32'(h * 'h100);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_host(input int h, input logic v);
    tl_h2d_t r;
    r           = '0;
    r.a_valid   = v;
    r.a_opcode  = 3'd4;
    r.a_size    = 2'd2;
    r.a_source  = src_of(h);
    r.a_address = addr_of(h);
    r.a_mask    = 4'hF;
    r.d_ready   = 1'b1;
    bus.tl_h_req[h] = r;
  endtask

  task automatic expect_req(input int h);
    req_t e;
    e.host = h;
    e.src  = 8'((src_of(h) << 2) | h);
    e.addr = addr_of(h);
    exp_req.push_back(e);
  endtask

  task automatic drive_rsp(input int h, input logic [7:0] orig);
    rsp_t e;
    bus.tl_d_rsp.d_valid  = 1'b1;
    bus.tl_d_rsp.d_opcode = 3'd1;
    bus.tl_d_rsp.d_source = 8'((orig << 2) | h);
    bus.tl_d_rsp.d_data   = 32'hD0D0_0000 | 32'(orig);
    e.host = h;
    e.src  = orig;
    exp_rsp.push_back(e);
  endtask

  task automatic send_rsp(input int h, input logic [7:0] orig);
    drive_rsp(h, orig);
    tick();
    bus.tl_d_rsp.d_valid = 1'b0;
  endtask

  // Scoreboard: pop on every device-side request accept and host-side response accept.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (bus.tl_d_req.a_valid && bus.tl_d_rsp.a_ready) begin
        check("req_pending", 32'(exp_req.size() != 0), 32'd1);
        if (exp_req.size() != 0) begin
          req_t e;
          e = exp_req.pop_front();
          $display("[TB] req accept host=%0d src=0x%0h addr=0x%0h", e.host,
                   bus.tl_d_req.a_source, bus.tl_d_req.a_address);
          check("req_src", 32'(bus.tl_d_req.a_source), 32'(e.src));
          check("req_addr", bus.tl_d_req.a_address, e.addr);
        end
      end
      for (int i = 0; i < M; i++) begin
        if (bus.tl_h_rsp[i].d_valid && bus.tl_h_req[i].d_ready) begin
          check("rsp_pending", 32'(exp_rsp.size() != 0), 32'd1);
          if (exp_rsp.size() != 0) begin
            rsp_t e;
            e = exp_rsp.pop_front();
            $display("[TB] rsp accept host=%0d src=0x%0h", i, bus.tl_h_rsp[i].d_source);
            check("rsp_host", 32'(i), 32'(e.host));
            check("rsp_src", 32'(bus.tl_h_rsp[i].d_source), 32'(e.src));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int h = 0; h < M; h++) set_host(h, 1'b0);
    bus.tl_d_rsp = '0;

    // Reset state
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_valid", 32'(bus.tl_d_req.a_valid), 32'd0);
    check("rst_gnt", 32'(bus.gnt_idx), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    for (int h = 0; h < M; h++) check("rst_d_valid", 32'(bus.tl_h_rsp[h].d_valid), 32'd0);
    tick();
    rst_ni = 1'b1;

    // T1 round-robin
    bus.tl_d_rsp.a_ready = 1'b1;
    for (int h = 0; h < M; h++) set_host(h, 1'b1);
    for (int c = 0; c < 4; c++) begin
      expect_req(c % M);
      @(negedge clk);
      check("t1_gnt", 32'(bus.gnt_idx), 32'(c % M));
      tick();
    end
    for (int h = 0; h < M; h++) set_host(h, 1'b0);
    send_rsp(0, 8'h01);
    send_rsp(0, 8'h02);

    // T4 response routing with a literal tagged source
    bus.tl_d_rsp.d_valid  = 1'b1;
    bus.tl_d_rsp.d_source = 8'h29;
    exp_rsp.push_back('{1, 8'h0A});
    @(negedge clk);
    check("t4_h0_d_valid", 32'(bus.tl_h_rsp[0].d_valid), 32'd0);
    check("t4_h1_d_valid", 32'(bus.tl_h_rsp[1].d_valid), 32'd1);
    check("t4_h2_d_valid", 32'(bus.tl_h_rsp[2].d_valid), 32'd0);
    check("t4_h1_src", 32'(bus.tl_h_rsp[1].d_source), 32'h0A);
    tick();
    bus.tl_d_rsp.d_valid = 1'b0;
    send_rsp(2, 8'h03);
    @(negedge clk);
    check("t1_busy_drained", 32'(bus.busy), 32'd0);
    tick();

    // T2 hold during device stall
    bus.tl_d_rsp.a_ready = 1'b0;
    set_host(1, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) set_host(0, 1'b1);
      @(negedge clk);
      check("t2_gnt_hold", 32'(bus.gnt_idx), 32'd1);
      check("t2_a_valid", 32'(bus.tl_d_req.a_valid), 32'd1);
      check("t2_addr_stable", bus.tl_d_req.a_address, addr_of(1));
      tick();
    end
    bus.tl_d_rsp.a_ready = 1'b1;
    expect_req(1);
    @(negedge clk);
    check("t2_gnt_accept", 32'(bus.gnt_idx), 32'd1);
    check("t2_h1_a_ready", 32'(bus.tl_h_rsp[1].a_ready), 32'd1);
    check("t2_h0_a_ready", 32'(bus.tl_h_rsp[0].a_ready), 32'd0);
    tick();
    set_host(1, 1'b0);
    expect_req(0);
    @(negedge clk);
    check("t2_gnt_next", 32'(bus.gnt_idx), 32'd0);
    tick();
    set_host(0, 1'b0);
    send_rsp(1, 8'h04);
    send_rsp(0, 8'h05);

    // T3 outstanding limit on host 2
    set_host(2, 1'b1);
    for (int c = 0; c < MO; c++) begin
      expect_req(2);
      tick();
    end
    drive_rsp(2, 8'h06);
    @(negedge clk);
    check("t3_limit_a_valid", 32'(bus.tl_d_req.a_valid), 32'd0);
    check("t3_limit_a_ready", 32'(bus.tl_h_rsp[2].a_ready), 32'd0);
    check("t3_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.tl_d_rsp.d_valid = 1'b0;
    expect_req(2);
    @(negedge clk);
    check("t3_regrant_a_valid", 32'(bus.tl_d_req.a_valid), 32'd1);
    check("t3_regrant_gnt", 32'(bus.gnt_idx), 32'd2);
    tick();
    set_host(2, 1'b0);
    for (int k = 0; k < MO; k++) send_rsp(2, 8'(8'h20 + k));
    @(negedge clk);
    check("t3_busy_drained", 32'(bus.busy), 32'd0);
    tick();

    // T5 simultaneous request and response accept for host 0
    set_host(0, 1'b1);
    expect_req(0);
    tick();
    expect_req(0);
    tick();
    expect_req(0);
    drive_rsp(0, 8'h07);
    @(negedge clk);
    check("t5_busy_same", 32'(bus.busy), 32'd1);
    tick();
    bus.tl_d_rsp.d_valid = 1'b0;
    set_host(0, 1'b0);
    send_rsp(0, 8'h08);
    @(negedge clk);
    check("t5_busy_one_left", 32'(bus.busy), 32'd1);
    tick();
    send_rsp(0, 8'h09);
    @(negedge clk);
    check("t5_busy_zero", 32'(bus.busy), 32'd0);
    tick();

    // T6 reset mid-LOCK with counters 3,1,0
    set_host(0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      expect_req(0);
      tick();
    end
    set_host(0, 1'b0);
    set_host(1, 1'b1);
    expect_req(1);
    tick();
    set_host(1, 1'b0);
    bus.tl_d_rsp.a_ready = 1'b0;
    set_host(2, 1'b1);
    @(negedge clk);
    check("t6_lock_gnt", 32'(bus.gnt_idx), 32'd2);
    tick();
    #2;
    for (int h = 0; h < M; h++) set_host(h, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_a_valid", 32'(bus.tl_d_req.a_valid), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_gnt", 32'(bus.gnt_idx), 32'd0);
    tick();
    rst_ni = 1'b1;
    bus.tl_d_rsp.a_ready = 1'b1;
    for (int h = 0; h < M; h++) set_host(h, 1'b1);
    expect_req(0);
    @(negedge clk);
    check("t6_restart_gnt", 32'(bus.gnt_idx), 32'd0);
    tick();
    for (int h = 0; h < M; h++) set_host(h, 1'b0);
    tick();

    check("req_queue_empty", 32'(exp_req.size()), 32'd0);
    check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
